// File: rtl/note_color_serializer_if.sv
// Bundles the NoteFinder note array, the start pulse, the beat stream and the frame status
// between note_color_serializer (master) and its surroundings (slave).
interface note_color_serializer_if #(
  parameter int N = 16
);
  logic [N-1:0] note_position  [12];
  logic [N-1:0] note_amplitude [12];
  logic         note_valid     [12];
  logic         start;

  // Stream handshake: a beat transfers on a rising clk edge where outValid && outReady;
  // while outValid is high without outReady, outSlot/outHue/outValue hold stable, and
  // outValid never drops before the beat transfers (except on rst).
  logic         outValid;
  logic         outReady;
  logic [3:0]   outSlot;
  logic [7:0]   outHue;
  logic [7:0]   outValue;

  logic         busy;
  logic         done;
  logic [11:0]  totalValue;

  modport master (
    input  note_position, note_amplitude, note_valid, start, outReady,
    output outValid, outSlot, outHue, outValue, busy, done, totalValue
  );

  modport slave (
    output note_position, note_amplitude, note_valid, start, outReady,
    input  outValid, outSlot, outHue, outValue, busy, done, totalValue
  );
endinterface

// File: rtl/note_color_serializer.sv
// Snapshots a 12-note frame and streams one (slot, hue, brightness) beat per note, then pulses done.
// Optional macro NOTE_EMIT_EMPTY_SLOTS_EN: invalid slots emit a zero beat instead of being skipped.
module note_color_serializer #(
  parameter int N         = 16,
  parameter int BPO       = 24,
  parameter int FPF       = 11,
  parameter int AMP_FLOOR = 64,
  parameter int AMP_SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  note_color_serializer_if.master io,
  output logic [1:0]              state_dbg
);

  localparam int K = ((1 << 16) + BPO / 2) / BPO;
  localparam int HUE_SHIFT = FPF + 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   slot_q, slot_d;
  logic [7:0]   hue_q, hue_d;
  logic [7:0]   value_q, value_d;
  logic [11:0]  sum_q, sum_d;
  logic [11:0]  total_q, total_d;
  logic [N-1:0] snap_pos_q [12];
  logic [N-1:0] snap_pos_d [12];
  logic [N-1:0] snap_amp_q [12];
  logic [N-1:0] snap_amp_d [12];
  logic         snap_valid_q [12];
  logic         snap_valid_d [12];

  logic [31:0]  hue_product;
  logic [7:0]   hue_calc;
  logic [N-1:0] amp_cur;
  logic [N-1:0] amp_floored;
  logic [N-1:0] amp_scaled;
  logic [7:0]   value_calc;
  logic [12:0]  sum_ext;
  logic [11:0]  sum_sat;

  // Hue wraps mod 256, so a position of exactly one octave lands back on 0.
  always_comb begin
    hue_product = 32'(snap_pos_q[slot_q]) * 32'(K);
    hue_calc    = 8'(hue_product >> HUE_SHIFT);
  end

  always_comb begin
    amp_cur     = snap_amp_q[slot_q];
    amp_floored = (amp_cur > N'(AMP_FLOOR)) ? (amp_cur - N'(AMP_FLOOR)) : '0;
    amp_scaled  = amp_floored >> AMP_SHIFT;
    value_calc  = (amp_scaled > N'(255)) ? 8'hff : amp_scaled[7:0];
  end

  always_comb begin
    sum_ext = {1'b0, sum_q} + {5'b0, value_q};
    sum_sat = sum_ext[12] ? 12'hfff : sum_ext[11:0];
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    hue_d        = hue_q;
    value_d      = value_q;
    sum_d        = sum_q;
    total_d      = total_q;
    snap_pos_d   = snap_pos_q;
    snap_amp_d   = snap_amp_q;
    snap_valid_d = snap_valid_q;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          snap_pos_d   = io.note_position;
          snap_amp_d   = io.note_amplitude;
          snap_valid_d = io.note_valid;
          slot_d       = 4'd0;
          sum_d        = 12'd0;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        if (snap_valid_q[slot_q]) begin
          hue_d   = hue_calc;
          value_d = value_calc;
          state_d = EMIT;
        end else begin
`ifdef NOTE_EMIT_EMPTY_SLOTS_EN
          hue_d   = 8'd0;
          value_d = 8'd0;
          state_d = EMIT;
`else
          if (slot_q == 4'd11) begin
            total_d = sum_q;
            state_d = DONE;
          end else begin
            slot_d = slot_q + 4'd1;
          end
`endif
        end
      end
      EMIT: begin
        if (io.outReady) begin
          sum_d = sum_sat;
          if (slot_q == 4'd11) begin
            total_d = sum_sat;
            state_d = DONE;
          end else begin
            slot_d  = slot_q + 4'd1;
            state_d = SCAN;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= 4'd0;
      hue_q   <= 8'd0;
      value_q <= 8'd0;
      sum_q   <= 12'd0;
      total_q <= 12'd0;
      for (int i = 0; i < 12; i++) begin
        snap_pos_q[i]   <= '0;
        snap_amp_q[i]   <= '0;
        snap_valid_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      hue_q        <= hue_d;
      value_q      <= value_d;
      sum_q        <= sum_d;
      total_q      <= total_d;
      snap_pos_q   <= snap_pos_d;
      snap_amp_q   <= snap_amp_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign io.outValid   = (state_q == EMIT);
  assign io.outSlot    = slot_q;
  assign io.outHue     = hue_q;
  assign io.outValue   = value_q;
  assign io.busy       = (state_q == SCAN) || (state_q == EMIT);
  assign io.done       = (state_q == DONE);
  assign io.totalValue = total_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_note_color_serializer.sv
// Directed bench for note_color_serializer: expected beats are queued at start and popped as the stream accepts them.
module tb_note_color_serializer;
  localparam int N = 16;
`ifdef NOTE_EMIT_EMPTY_SLOTS_EN
  localparam bit EMPTY_EN = 1'b1;
`else
  localparam bit EMPTY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  note_color_serializer_if #(.N(N)) ifc ();

  note_color_serializer #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (ifc),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          beats    = 0;
  logic [19:0] exp_q[$];
  logic [7:0]  exp_hue [12];
  logic [7:0]  exp_val [12];
  logic [11:0] exp_total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : beat_monitor
    logic [19:0] got;
    logic [19:0] want;
    if (!rst && ifc.outValid === 1'b1 && ifc.outReady === 1'b1) begin
      beats++;
      got = {ifc.outSlot, ifc.outHue, ifc.outValue};
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check("beat_slot_hue_value", 32'(got), 32'(want));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_notes();
    for (int i = 0; i < 12; i++) begin
      ifc.note_valid[i]     = 1'b0;
      ifc.note_position[i]  = '0;
      ifc.note_amplitude[i] = '0;
      exp_hue[i] = 8'd0;
      exp_val[i] = 8'd0;
    end
  endtask

  task automatic set_note(input int slot, input int pos, input int amp, input int hue, input int val);
    ifc.note_valid[slot]     = 1'b1;
    ifc.note_position[slot]  = N'(pos);
    ifc.note_amplitude[slot] = N'(amp);
    exp_hue[slot] = 8'(hue);
    exp_val[slot] = 8'(val);
  endtask

  task automatic push_expected();
    int t;
    t = 0;
    beats = 0;
    for (int s = 0; s < 12; s++) begin
      if (ifc.note_valid[s]) begin
        exp_q.push_back({4'(s), exp_hue[s], exp_val[s]});
        t = t + int'(exp_val[s]);
        if (t > 4095) t = 4095;
      end else if (EMPTY_EN) begin
        exp_q.push_back({4'(s), 8'd0, 8'd0});
      end
    end
    exp_total = 12'(t);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 ifc.start = 1'b1;
    @(posedge clk); #1 ifc.start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (ifc.outValid === 1'b1) seen = 1'b1;
    end
  endtask

  // Counts negedges from the start-sampling edge until done is seen, then checks the frame.
  task automatic finish_frame(input string tag, input int exp_lat, input int exp_beats);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      if (ifc.done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (exp_lat > 0) check({tag, "_done_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_busy_in_done"}, 32'(ifc.busy), 32'd0);
    check({tag, "_total"}, 32'(ifc.totalValue), 32'(exp_total));
    check({tag, "_beats"}, 32'(beats), 32'(exp_beats));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(ifc.done), 32'd0);
    check({tag, "_total_held"}, 32'(ifc.totalValue), 32'(exp_total));
    exp_q.delete();
  endtask

  localparam int HUE_SEMI [12] = '{0, 10, 21, 32, 42, 53, 64, 74, 85, 96, 106, 117};

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    bit seen;
    int lat_single;
    lat_single = EMPTY_EN ? 25 : 14;
    ifc.start    = 1'b0;
    ifc.outReady = 1'b0;
    clear_notes();

    // reset held 5 cycles
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_outValid", 32'(ifc.outValid), 32'd0);
    check("rst_outSlot", 32'(ifc.outSlot), 32'd0);
    check("rst_outHue", 32'(ifc.outHue), 32'd0);
    check("rst_outValue", 32'(ifc.outValue), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_totalValue", 32'(ifc.totalValue), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    // single note, ready always high
    ifc.outReady = 1'b1;
    clear_notes();
    set_note(3, 24576, 4160, 128, 64);
    push_expected();
    pulse_start();
    check("single_busy", 32'(ifc.busy), 32'd1);
    finish_frame("single", lat_single, EMPTY_EN ? 12 : 1);

    // backpressure: first beat must hold for 10 cycles
    ifc.outReady = 1'b0;
    clear_notes();
    set_note(0, 1024, 16448, 5, 255);
    set_note(11, 49131, 100, 255, 0);
    push_expected();
    pulse_start();
    wait_valid(40, seen);
    check("bp_valid_seen", 32'(seen), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(ifc.outValid), 32'd1);
      check("bp_hold_slot", 32'(ifc.outSlot), 32'd0);
      check("bp_hold_hue", 32'(ifc.outHue), 32'd5);
      check("bp_hold_value", 32'(ifc.outValue), 32'd255);
    end
    @(posedge clk); #1 ifc.outReady = 1'b1;
    finish_frame("bp", -1, EMPTY_EN ? 12 : 2);

    // all slots saturate
    clear_notes();
    for (int s = 0; s < 12; s++) set_note(s, s * 2048, 65535, HUE_SEMI[s], 255);
    push_expected();
    check("sat_total_model", 32'(exp_total), 32'd3060);
    pulse_start();
    finish_frame("sat", 25, 12);

    // amplitude under the noise floor
    clear_notes();
    set_note(7, 12288, 50, 64, 0);
    push_expected();
    pulse_start();
    finish_frame("floor", lat_single, EMPTY_EN ? 12 : 1);

    // no valid notes
    clear_notes();
    push_expected();
    pulse_start();
    finish_frame("empty", EMPTY_EN ? 25 : 13, EMPTY_EN ? 12 : 0);

    // start while busy with changed notes is ignored
    clear_notes();
    set_note(3, 24576, 4160, 128, 64);
    push_expected();
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    ifc.note_valid[5]     = 1'b1;
    ifc.note_position[5]  = 16'd4096;
    ifc.note_amplitude[5] = 16'd65535;
    ifc.note_amplitude[3] = 16'd0;
    pulse_start();
    finish_frame("restart", -1, EMPTY_EN ? 12 : 1);

    // asynchronous reset while a beat is pending
    ifc.outReady = 1'b0;
    clear_notes();
    set_note(2, 24576, 4160, 128, 64);
    push_expected();
    pulse_start();
    wait_valid(40, seen);
    check("arst_valid_seen", 32'(seen), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_outValid", 32'(ifc.outValid), 32'd0);
    check("arst_busy", 32'(ifc.busy), 32'd0);
    check("arst_outSlot", 32'(ifc.outSlot), 32'd0);
    check("arst_outHue", 32'(ifc.outHue), 32'd0);
    check("arst_state", 32'(state_dbg), 32'd0);
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("arst_no_done", 32'(ifc.done), 32'd0);
    end
    rst = 1'b0;
    ifc.outReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("arst_after_idle", 32'({ifc.done, ifc.busy, ifc.outValid}), 32'd0);
    end
    check("arst_total_cleared", 32'(ifc.totalValue), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
